// File: rtl/dff_bank_arbiter.sv
// Round-robin write scheduler for a single shared WIDTH-bit register.
// One requester owns the register at a time, for at most HOLD_MAX captures per tenure.
module dff_bank_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]           q,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] q_owner,
  output logic                       q_upd
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(HOLD_MAX + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]         state_reg;
  logic [IW-1:0]      owner_reg;
  logic [IW-1:0]      ptr_reg;
  logic [CW-1:0]      cnt_reg;

  logic               own_req;
  logic               capture;
  logic               release_now;
  logic [CW-1:0]      cnt_next;
  logic [IW-1:0]      owner_next;
  logic [WIDTH-1:0]   lane_sel;
  logic               hit;
  logic [IW-1:0]      win;
  logic [NUM_REQ-1:0] win_oh;

  assign own_req    = req[owner_reg];
  assign capture    = (state_reg == GRANT) && own_req;
  assign cnt_next   = cnt_reg + CW'(1);
  assign owner_next = (owner_reg == IW'(NUM_REQ - 1)) ? '0 : owner_reg + IW'(1);
  assign lane_sel   = data[int'(owner_reg)*WIDTH +: WIDTH];
  // A tenure ends when the owner drops its request or its capture budget runs out.
  assign release_now = (state_reg == GRANT) && (!own_req || (cnt_next == CW'(HOLD_MAX)));

  // On release the search starts just past the outgoing owner, so it is only
  // re-granted when nobody else is asking.
  always_comb begin
    int base;
    int idx;
    hit  = 1'b0;
    win  = '0;
    base = (state_reg == GRANT) ? int'(owner_next) : int'(ptr_reg);
    idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (base + k) % NUM_REQ;
      if (!hit && req[idx]) begin
        hit = 1'b1;
        win = IW'(idx);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_oh
      assign win_oh[gi] = hit && (win == IW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      gnt       <= '0;
      q         <= '0;
      q_owner   <= '0;
      q_upd     <= 1'b0;
    end else begin
      q_upd <= capture;
      if (capture) begin
        q       <= lane_sel;
        q_owner <= owner_reg;
      end
      case (state_reg)
        IDLE: begin
          if (hit) begin
            state_reg <= GRANT;
            owner_reg <= win;
            gnt       <= win_oh;
            cnt_reg   <= '0;
          end
        end
        default: begin
          if (release_now) begin
            ptr_reg <= owner_next;
            cnt_reg <= '0;
            if (hit) begin
              owner_reg <= win;
              gnt       <= win_oh;
            end else begin
              state_reg <= IDLE;
              gnt       <= '0;
            end
          end else if (capture) begin
            cnt_reg <= cnt_next;
          end
        end
      endcase
    end
  end

endmodule
